// File: rtl/min3_share_ctrl_if.sv
// rtl/min3_share_ctrl_if.sv - requester and result channels of the shared min3 controller
interface min3_share_ctrl_if #(
    parameter int W = 8
);
    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic [W-1:0] req0_c;

    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic [W-1:0] req1_c;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_min;
    logic         out_id;

    // Controller side: consumes triples, produces tagged results
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_c,
        input  req1_valid, req1_a, req1_b, req1_c,
        input  out_ready,
        output req0_ready, req1_ready,
        output out_valid, out_min, out_id
    );

    // Environment side: requesters plus downstream consumer
    modport master (
        output req0_valid, req0_a, req0_b, req0_c,
        output req1_valid, req1_a, req1_b, req1_c,
        output out_ready,
        input  req0_ready, req1_ready,
        input  out_valid, out_min, out_id
    );
endinterface

// File: rtl/min3_share_ctrl.sv
// rtl/min3_share_ctrl.sv - round-robin shared two-pass min(a,b,c) controller
module min3_share_ctrl #(
    parameter int W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    min3_share_ctrl_if.slave    ctrl
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP1 = 2'd1,
        CMP2 = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic         rr_ptr_q, rr_ptr_d;
    logic         id_q, id_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [W-1:0] c_q, c_d;
    logic [W-1:0] cmp_q, cmp_d;

    logic         both_valid;
    logic         win_id;
    logic         ready0;
    logic         ready1;
    logic         accept;
    logic [W-1:0] cmp_x;
    logic [W-1:0] cmp_y;
    logic [W-1:0] cmp_min;

    // Contention resolved by rr_ptr; a lone requester always wins.
    // Grants are suppressed while reset is held so nothing is acknowledged then.
    always_comb begin
        both_valid = ctrl.req0_valid & ctrl.req1_valid;
        win_id     = both_valid ? rr_ptr_q : ctrl.req1_valid;
        ready0     = rst_n & (state_q == IDLE) & ctrl.req0_valid & ~win_id;
        ready1     = rst_n & (state_q == IDLE) & ctrl.req1_valid &  win_id;
        accept     = ready0 | ready1;
    end

    // Single comparator: first pass (a,b), second pass (running min, c).
    // Ties keep the x-side operand; the value is the same either way.
    always_comb begin
        cmp_x   = (state_q == CMP2) ? cmp_q : a_q;
        cmp_y   = (state_q == CMP2) ? c_q   : b_q;
        cmp_min = (cmp_x > cmp_y) ? cmp_y : cmp_x;
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        cmp_d    = cmp_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d      = win_id ? ctrl.req1_a : ctrl.req0_a;
                    b_d      = win_id ? ctrl.req1_b : ctrl.req0_b;
                    c_d      = win_id ? ctrl.req1_c : ctrl.req0_c;
                    id_d     = win_id;
                    rr_ptr_d = ~win_id;
                    state_d  = CMP1;
                end
            end
            CMP1: begin
                cmp_d   = cmp_min;
                state_d = CMP2;
            end
            CMP2: begin
                cmp_d   = cmp_min;
                state_d = DONE;
            end
            DONE: begin
                if (ctrl.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= 1'b0;
            id_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            cmp_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            cmp_q    <= cmp_d;
        end
    end

    // Result registers only change outside DONE, so outputs hold under backpressure
    assign ctrl.req0_ready = ready0;
    assign ctrl.req1_ready = ready1;
    assign ctrl.out_valid  = (state_q == DONE);
    assign ctrl.out_min    = cmp_q;
    assign ctrl.out_id     = id_q;

endmodule

// File: tb/tb_min3_share_ctrl.sv
// tb/tb_min3_share_ctrl.sv - directed self-checking bench for min3_share_ctrl
module tb_min3_share_ctrl;

    logic clk;
    logic rst_n;
    int   chk_cnt;
    int   pass_cnt;

    min3_share_ctrl_if #(.W(8)) bus ();

    min3_share_ctrl #(.W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic set_req0(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        bus.req0_valid = v;
        bus.req0_a     = a;
        bus.req0_b     = b;
        bus.req0_c     = c;
    endtask

    task automatic set_req1(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        bus.req1_valid = v;
        bus.req1_a     = a;
        bus.req1_b     = b;
        bus.req1_c     = c;
    endtask

    // Wait (bounded) for out_valid at a negedge, then check the tagged result
    task automatic collect(input string tag, input logic [7:0] exp_min, input logic exp_id);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.out_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_min"}, 32'(bus.out_min), 32'(exp_min));
        check({tag, "_id"}, 32'(bus.out_id), 32'(exp_id));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        rst_n    = 1'b0;
        bus.out_ready = 1'b0;
        set_req0(1'b1, 8'd30, 8'd10, 8'd20);
        set_req1(1'b0, 8'd0, 8'd0, 8'd0);

        // Reset state, with a request already pending
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_min", 32'(bus.out_min), 32'd0);
        check("rst_out_id", 32'(bus.out_id), 32'd0);
        check("rst_req0_ready", 32'(bus.req0_ready), 32'd0);

        // Single request: accept cycle, then two compare cycles, DONE in the fourth
        rst_n = 1'b1;
        #1;
        check("t1_req0_ready", 32'(bus.req0_ready), 32'd1);
        check("t1_req1_ready", 32'(bus.req1_ready), 32'd0);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        check("t1_cmp1_ready", 32'(bus.req0_ready), 32'd0);
        check("t1_cmp1_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("t1_cmp2_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("t1_done_valid", 32'(bus.out_valid), 32'd1);
        check("t1_min", 32'(bus.out_min), 32'd10);
        check("t1_id", 32'(bus.out_id), 32'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("t1_drop_valid", 32'(bus.out_valid), 32'd0);

        // Simultaneous requests after reset: grants alternate starting at 0
        pulse_reset();
        set_req0(1'b1, 8'd5, 8'd9, 8'd7);
        set_req1(1'b1, 8'd4, 8'd3, 8'd8);
        #1;
        check("t2_first_grant0", 32'(bus.req0_ready), 32'd1);
        check("t2_first_grant1", 32'(bus.req1_ready), 32'd0);
        collect("t2_r0", 8'd5, 1'b0);
        collect("t2_r1", 8'd3, 1'b1);
        collect("t2_r2", 8'd5, 1'b0);
        collect("t2_r3", 8'd3, 1'b1);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        // Unsigned extremes; lone requester 1 served twice regardless of rr_ptr
        @(negedge clk);
        set_req1(1'b1, 8'h80, 8'h7F, 8'hFF);
        collect("t3_r1a", 8'h7F, 1'b1);
        collect("t3_r1b", 8'h7F, 1'b1);
        bus.req1_valid = 1'b0;
        set_req0(1'b1, 8'd0, 8'd255, 8'd0);
        collect("t3_r0", 8'd0, 1'b0);
        bus.req0_valid = 1'b0;

        // Backpressure with a tie triple; both requesters pending during DONE
        @(negedge clk);
        bus.out_ready = 1'b0;
        set_req0(1'b1, 8'd42, 8'd42, 8'd42);
        collect("t4_tie", 8'd42, 1'b0);
        set_req0(1'b1, 8'd1, 8'd1, 8'd1);
        set_req1(1'b1, 8'd2, 8'd2, 8'd2);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("t4_hold%0d_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("t4_hold%0d_min", i), 32'(bus.out_min), 32'd42);
            check($sformatf("t4_hold%0d_id", i), 32'(bus.out_id), 32'd0);
            check($sformatf("t4_hold%0d_rdy0", i), 32'(bus.req0_ready), 32'd0);
            check($sformatf("t4_hold%0d_rdy1", i), 32'(bus.req1_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("t4_after_valid", 32'(bus.out_valid), 32'd0);
        check("t4_rr_rdy1", 32'(bus.req1_ready), 32'd1);
        check("t4_rr_rdy0", 32'(bus.req0_ready), 32'd0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        // Reset during CMP2 discards the transaction; req1 served after release
        @(negedge clk);
        set_req0(1'b1, 8'd9, 8'd8, 8'd7);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        set_req1(1'b1, 8'd100, 8'd200, 8'd50);
        #1;
        check("t5_rst_valid", 32'(bus.out_valid), 32'd0);
        check("t5_rst_min", 32'(bus.out_min), 32'd0);
        check("t5_rst_rdy1", 32'(bus.req1_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t5_rel_rdy1", 32'(bus.req1_ready), 32'd1);
        collect("t5_r1", 8'd50, 1'b1);
        bus.req1_valid = 1'b0;
        @(negedge clk);
        check("t5_idle_valid", 32'(bus.out_valid), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
